// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side branch predictor and EX-stage resolution unit
// for the 16-bit pipelined core.
//  - Direct-mapped BTB (2^IDX_BITS entries) with valid/tag/target and a 2-bit
//    saturating counter per entry, held in flip-flops.
//  - 0-cycle lookup for the IF-stage PC; combinational mispredict/redirect
//    from the EX-stage resolved branch condition; training at the clock edge.
//  - A lookup and an update to the same index in one cycle do not bypass:
//    the lookup sees the pre-update entry.
// Optional feature macro: BP_STATS_EN adds saturating statistics counters
// (stat_branches, stat_mispredicts).
module branch_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic                 ex_bcond,
  input  logic [WORD_SIZE-1:0] ex_target,
  input  logic                 ex_pred_taken,
  input  logic [WORD_SIZE-1:0] ex_pred_target,
`ifdef BP_STATS_EN
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts,
`endif
  output logic                 mispredict,
  output logic [WORD_SIZE-1:0] redirect_pc
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;
  localparam logic [WORD_SIZE-1:0] PC_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  // Two-bit counter step that holds at 00 and 11 instead of wrapping.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // BTB storage
  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  // Lookup side
  logic [IDX_BITS-1:0]  lk_idx;
  logic                 lk_hit;
  logic [WORD_SIZE-1:0] if_pc_inc;

  // Resolution / training side
  logic                 ex_active;
  logic [IDX_BITS-1:0]  up_idx;
  logic                 up_hit;
  logic [WORD_SIZE-1:0] ex_pc_inc;
  logic [WORD_SIZE-1:0] actual_next;
  logic                 up_we;
  logic                 upd_valid_d;
  logic [TAG_W-1:0]     upd_tag_d;
  logic [WORD_SIZE-1:0] upd_target_d;
  logic [1:0]           upd_ctr_d;

  // Prediction for the fetch PC straight from table state (no bypass).
  always_comb begin
    lk_idx      = if_pc[IDX_BITS-1:0];
    if_pc_inc   = if_pc + PC_ONE;
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == if_pc[WORD_SIZE-1:IDX_BITS]);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = pred_taken ? target_q[lk_idx] : if_pc_inc;
  end

  // Mispredict detection and redirect PC for the instruction in EX.
  always_comb begin
    ex_active   = ex_valid && ex_is_branch;
    ex_pc_inc   = ex_pc + PC_ONE;
    actual_next = ex_bcond ? ex_target : ex_pc_inc;
    redirect_pc = actual_next;
    mispredict  = 1'b0;
    if (ex_active) begin
      if (ex_bcond != ex_pred_taken)
        mispredict = 1'b1;
      else if (ex_bcond && ex_pred_taken && (ex_target != ex_pred_target))
        mispredict = 1'b1;
    end
  end

  // Next value of the entry indexed by the resolving branch.
  always_comb begin
    up_idx       = ex_pc[IDX_BITS-1:0];
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == ex_pc[WORD_SIZE-1:IDX_BITS]);
    up_we        = 1'b0;
    upd_valid_d  = valid_q[up_idx];
    upd_tag_d    = tag_q[up_idx];
    upd_target_d = target_q[up_idx];
    upd_ctr_d    = ctr_q[up_idx];
    if (ex_active) begin
      if (up_hit) begin
        // Known branch: train the counter, refresh the target when taken.
        up_we     = 1'b1;
        upd_ctr_d = ctr_step(ctr_q[up_idx], ex_bcond);
        if (ex_bcond) upd_target_d = ex_target;
      end else if (ex_bcond) begin
        // Taken branch not in the table: allocate (or evict the alias),
        // starting weakly taken.
        up_we        = 1'b1;
        upd_valid_d  = 1'b1;
        upd_tag_d    = ex_pc[WORD_SIZE-1:IDX_BITS];
        upd_target_d = ex_target;
        upd_ctr_d    = 2'b10;
      end
      // Not-taken miss leaves the table untouched.
    end
  end

  // Table update; reset wins over a same-cycle training write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (up_we) begin
      valid_q[up_idx]  <= upd_valid_d;
      tag_q[up_idx]    <= upd_tag_d;
      target_q[up_idx] <= upd_target_d;
      ctr_q[up_idx]    <= upd_ctr_d;
    end
  end

`ifdef BP_STATS_EN
  // Sixteen-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_mp_q, stat_mp_d;

  // Next values of the statistics counters.
  always_comb begin
    stat_br_d = ex_active  ? sat_inc16(stat_br_q) : stat_br_q;
    stat_mp_d = mispredict ? sat_inc16(stat_mp_q) : stat_mp_q;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and resolution unit for the 16-bit pipelined core.
- Gives a taken/target prediction for the IF-stage PC every cycle.
- Consumes the EX-stage branch condition (bcond) produced by the branch comparator, detects mispredictions and supplies the redirect PC.
- Trains a direct-mapped BTB with 2-bit saturating counters.

Parameters:
- WORD_SIZE, 16, datapath/PC width.
- IDX_BITS, 4, BTB index width; 2^IDX_BITS entries; tag = PC[WORD_SIZE-1:IDX_BITS].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  WORD_SIZE  PC being fetched.
- pred_taken  output  1  prediction for if_pc; combinational from table state.
- pred_target  output  WORD_SIZE  predicted next PC (target if taken, else if_pc+1).
- ex_valid  input  1  EX stage holds a valid, non-flushed instruction.
- ex_is_branch  input  1  EX instruction is BNE/BEQ/BGZ/BLZ.
- ex_pc  input  WORD_SIZE  PC of the EX instruction.
- ex_bcond  input  1  resolved branch condition from the comparator.
- ex_target  input  WORD_SIZE  computed branch target (PC+1+imm).
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- ex_pred_target  input  WORD_SIZE  predicted next PC carried down the pipe.
- mispredict  output  1  flush IF/ID and redirect; combinational.
- redirect_pc  output  WORD_SIZE  correct next PC; valid when mispredict=1.

Behaviour:
- Storage per entry: valid (1), tag (WORD_SIZE-IDX_BITS), target (WORD_SIZE), ctr (2). Registers only, no RAM macro.
- Reset (sync, clk edge with reset=1):
  - all valid=0, all ctr=2'b01, tag/target=0.
  - Reset has priority over any same-cycle update.
  - Asserting reset mid-stream discards that cycle's training.
  - Outputs after reset: pred_taken=0, pred_target=if_pc+1. mispredict follows the ex_* inputs, since it is combinational.
- Lookup (0-cycle latency):
  - idx=if_pc[IDX_BITS-1:0].
  - hit = valid[idx] & tag[idx]==if_pc[WORD_SIZE-1:IDX_BITS].
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+1.
  - if_pc+1 is modulo 2^WORD_SIZE (0xFFFF -> 0x0000).
- Resolution (combinational), active only when ex_valid & ex_is_branch:
  - actual_next = ex_bcond ? ex_target : ex_pc+1 (modulo wrap).
  - mispredict=1 if ex_bcond != ex_pred_taken.
  - mispredict=1 if ex_bcond & ex_pred_taken & ex_target != ex_pred_target.
  - redirect_pc = actual_next.
  - Otherwise mispredict=0 and redirect_pc=actual_next (don't-care).
  - ex_valid=0 or ex_is_branch=0: mispredict=0, no training.
- Training (registered at clk edge when ex_valid & ex_is_branch & ~reset), with u=ex_pc[IDX_BITS-1:0]:
  - Hit at u: ctr saturating +1 if ex_bcond, else saturating -1. Bounds are 00 and 11; no wrap.
  - Hit at u and ex_bcond: target[u]=ex_target.
  - Miss at u and ex_bcond: allocate/replace; valid=1, tag=ex_pc upper bits, target=ex_target, ctr=2'b10.
  - Miss at u and not taken: no state change.
- Same-cycle lookup and update to the same index:
  - Lookup sees the pre-update state; no bypass.
  - The new state is visible from the next cycle.
- Stalls: the pipeline deasserts ex_valid for bubbles and stalled repeats; the block has no stall input.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds two outputs:
  - stat_branches [15:0]: counts resolved branches (ex_valid & ex_is_branch).
  - stat_mispredicts [15:0]: counts cycles with mispredict=1.
- Both counters are cleared by reset and saturate at 0xFFFF; no wrap.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x0010 -> pred_taken=0, pred_target=0x0011.
- Resolve ex_pc=0x0010, bcond=1, target=0x0020, pred_taken=0 -> mispredict=1, redirect_pc=0x0020. Next cycle if_pc=0x0010 -> pred_taken=1, pred_target=0x0020.
- Same branch resolved not-taken twice (ctr 10->01->00) -> first resolve mispredict=1 with redirect_pc=0x0011. Afterwards pred_taken=0. A third not-taken leaves ctr=00.
- Aliasing: with if_pc=0x0030 (same idx 0, different tag) after 0x0010 trained taken -> pred_taken=0. Train 0x0030 taken with target 0x0040 -> entry replaced; 0x0010 then predicts not-taken.
- Target mismatch: ex_pred_taken=1, ex_pred_target=0x0020, bcond=1, ex_target=0x0025 -> mispredict=1, redirect_pc=0x0025. Wrap case: ex_pc=0xFFFF not-taken, predicted taken -> redirect_pc=0x0000.
- Same-cycle update and lookup of one index -> lookup shows old prediction. Assert reset with a taken update pending -> table stays cleared. With BP_STATS_EN: 3 branches with 2 mispredicts -> stat_branches=3, stat_mispredicts=2.
